// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch stage.
//   - fetch_state_t : fetch control states
//   - fetch_slot_t  : {pc, instr} pair as presented to decode
//   - INSTR_BYTES   : PC increment per sequential fetch
//   - RESET_PC_DEF  : default first fetch address after reset
// ----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned PC_W_DEF     = 32;
  localparam int unsigned INSTR_W_DEF  = 32;
  localparam int unsigned INSTR_BYTES  = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_RESET,  // one idle cycle after reset release
    S_REQ,    // request presented to instruction memory
    S_WAIT,   // request accepted, waiting for the response strobe
    S_HOLD,   // response parked in the hold buffer, slot still occupied
    S_DRAIN   // redirected while a request was in flight; swallow its response
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_resp_buf.sv
// ----------------------------------------------------------------------------
// fetch_resp_buf
//   One-entry holding buffer for an instruction-memory response that arrived
//   while the decode slot was still occupied (memory has no backpressure).
// Ports
//   clk, rst         : clock, asynchronous active-high reset
//   load_i           : capture pc_i/instr_i, entry becomes valid
//   unload_i         : entry moved out, becomes empty
//   flush_i          : discard entry (redirect); wins over load/unload
//   pc_i, instr_i    : data to capture
//   valid_o          : entry holds data
//   pc_o, instr_o    : held data
// ----------------------------------------------------------------------------
module fetch_resp_buf #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               unload_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               valid_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  // NOTE: the payload is not reset; it is only observed while valid_q is set,
  // and valid_q is reset, so clearing the data would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (load_i && !flush_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// fetch_pc_unit
//   Fetch stage: owns the PC, issues one instruction-memory read at a time,
//   presents the fetched {pc, instr} to decode, and redirects on Branch from
//   the branch calculator, squashing any wrong-path response.
// Parameters
//   RESET_PC : first fetch address after reset
//   PC_W     : PC / address width
//   INSTR_W  : instruction width
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   Branch, BrPC    : redirect request and target (low two bits ignored)
//   imem_req        : read request valid (decoded from state)
//   imem_addr       : read address (= pc)
//   imem_rdy        : memory accepts the request this cycle
//   imem_rvalid     : one-cycle response strobe, no backpressure
//   imem_rdata      : response data
//   if_valid        : decode slot holds a valid instruction
//   if_pc, if_instr : contents of the decode slot
//   id_ready        : decode consumes the slot when if_valid && id_ready
//   fetch_misalign  : one-cycle pulse after a redirect to a misaligned BrPC
// Configuration
//   FETCH_ALIGN_CHECK_EN : when defined, fetch_misalign reports misaligned
//                          redirect targets; otherwise it is tied low.
// ----------------------------------------------------------------------------
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       PC_W     = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [PC_W-1:0]   RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Branch,
  input  logic [PC_W-1:0]    BrPC,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rdy,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [PC_W-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               id_ready,
  output logic               fetch_misalign
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    req_pc_q, req_pc_d;
  logic               slot_valid_q, slot_valid_d;
  logic [PC_W-1:0]    slot_pc_q, slot_pc_d;
  logic [INSTR_W-1:0] slot_instr_q, slot_instr_d;

  logic               buf_load, buf_unload, buf_flush, buf_valid;
  logic [PC_W-1:0]    buf_pc;
  logic [INSTR_W-1:0] buf_instr;

  logic               slot_free;
  logic               req_in_flight;
  logic [PC_W-1:0]    br_target;

  // The slot can take new data if it is empty or being consumed this cycle.
  assign slot_free = !slot_valid_q || id_ready;
  assign br_target = {BrPC[PC_W-1:2], 2'b00};

  // A redirect must swallow one response if a request has been accepted but
  // its response has not arrived by the end of this cycle.
  assign req_in_flight = ((state_q == S_REQ) && imem_rdy) ||
                         (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_rvalid);

  fetch_resp_buf #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_resp_buf (
    .clk      (clk),
    .rst      (rst),
    .load_i   (buf_load),
    .unload_i (buf_unload),
    .flush_i  (buf_flush),
    .pc_i     (req_pc_q),
    .instr_i  (imem_rdata),
    .valid_o  (buf_valid),
    .pc_o     (buf_pc),
    .instr_o  (buf_instr)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if structure leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    slot_valid_d = slot_valid_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
    buf_load     = 1'b0;
    buf_unload   = 1'b0;
    buf_flush    = 1'b0;

    // Consumption empties the slot unless a reload below overrides it.
    if (slot_valid_q && id_ready) begin
      slot_valid_d = 1'b0;
    end

    case (state_q)
      S_RESET: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_rdy) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_W'(INSTR_BYTES);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (slot_free) begin
            slot_valid_d = 1'b1;
            slot_pc_d    = req_pc_q;
            slot_instr_d = imem_rdata;
            state_d      = S_REQ;
          end else begin
            buf_load = 1'b1;
            state_d  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (slot_free && buf_valid) begin
          slot_valid_d = 1'b1;
          slot_pc_d    = buf_pc;
          slot_instr_d = buf_instr;
          buf_unload   = 1'b1;
          state_d      = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_RESET;
      end
    endcase

    // Redirect overrides everything: any response this cycle is dropped and
    // both the slot and the hold buffer are invalidated.
    if (Branch) begin
      pc_d         = br_target;
      slot_valid_d = 1'b0;
      buf_load     = 1'b0;
      buf_unload   = 1'b0;
      buf_flush    = 1'b1;
      state_d      = req_in_flight ? S_DRAIN : S_REQ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RESET;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      slot_valid_q <= 1'b0;
      slot_pc_q    <= '0;
      slot_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      slot_valid_q <= slot_valid_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= Branch && (BrPC[1:0] != 2'b00);
    end
  end

  assign fetch_misalign = misalign_q;
`else
  // Low target bits are simply dropped when the check is not built in.
  logic unused_brpc_lsbs;
  assign unused_brpc_lsbs = ^BrPC[1:0];
  assign fetch_misalign   = 1'b0;
`endif

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign if_valid  = slot_valid_q;
  assign if_pc     = slot_pc_q;
  assign if_instr  = slot_instr_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_pc_unit
//   Self-checking bench for fetch_pc_unit. Stimulus pushes expected request
//   addresses and expected decode-slot contents into queues; two monitors pop
//   and compare whenever the DUT issues an accepted request or hands an
//   instruction to decode. A small memory model answers accepted requests.
//   Build with FETCH_ALIGN_CHECK_EN to match a DUT built with that macro.
// ----------------------------------------------------------------------------
module tb_fetch_pc_unit;
  import fetch_pkg::*;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic EXP_MIS = 1'b1;
`else
  localparam logic EXP_MIS = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               Branch;
  logic [PC_W-1:0]    BrPC;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rdy;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               id_ready;
  logic               fetch_misalign;

  fetch_pc_unit #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Branch         (Branch),
    .BrPC           (BrPC),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdy       (imem_rdy),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .id_ready       (id_ready),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_slot_t  exp_slot_q[$];
  logic [31:0]  exp_addr_q[$];

  int mem_extra = 0;  // extra cycles before the response strobe
  int budget    = 0;  // number of requests the memory will still accept

  // Memory contents: a fixed, easily hand-derived function of the address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] a, input bit to_decode);
    fetch_slot_t s;
    exp_addr_q.push_back(a);
    if (to_decode) begin
      s.pc    = a;
      s.instr = instr_of(a);
      exp_slot_q.push_back(s);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_budget(input int n);
    budget   = n;
    imem_rdy = (n > 0);
  endtask

  // ---------------- memory model ----------------
  initial begin : mem_model
    bit          accept_now;
    logic [31:0] acc_addr;
    bit          pend;
    logic [31:0] pend_addr;
    int          wait_cnt;
    pend        = 1'b0;
    pend_addr   = '0;
    wait_cnt    = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    imem_rdy    = 1'b0;
    forever begin
      @(negedge clk);
      accept_now = !rst && imem_req && imem_rdy;
      acc_addr   = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (wait_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(pend_addr);
            pend        = 1'b0;
          end else begin
            wait_cnt--;
          end
        end
        if (accept_now) begin
          budget--;
          pend      = 1'b1;
          pend_addr = acc_addr;
          wait_cnt  = mem_extra;
          if (wait_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(pend_addr);
            pend        = 1'b0;
          end
        end
      end
      imem_rdy = (budget > 0);
    end
  end

  // ---------------- monitors ----------------
  initial begin : addr_monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && imem_req && imem_rdy) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL req_unexpected: got addr %h, expected no request", imem_addr);
        end else begin
          e = exp_addr_q.pop_front();
          check("req_addr", imem_addr, e);
        end
      end
    end
  end

  initial begin : slot_monitor
    fetch_slot_t e;
    forever begin
      @(negedge clk);
      if (!rst && if_valid && id_ready) begin
        if (exp_slot_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL slot_unexpected: got pc %h, expected empty slot", if_pc);
        end else begin
          e = exp_slot_q.pop_front();
          check("slot_pc", if_pc, e.pc);
          check("slot_instr", if_instr, e.instr);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, imem_req, 1'b0);
    check({tag, "_imem_addr"}, imem_addr, 32'h0000_0000);
    check({tag, "_if_valid"}, if_valid, 1'b0);
    check({tag, "_if_pc"}, if_pc, 32'h0000_0000);
    check({tag, "_if_instr"}, if_instr, 32'h0000_0000);
    check({tag, "_misalign"}, fetch_misalign, 1'b0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    Branch   = 1'b0;
    BrPC     = '0;
    id_ready = 1'b1;
    set_budget(0);
    repeat (2) tick();
    @(negedge clk);
    check_reset_outputs("rst");
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_accept(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (imem_req && imem_rdy) got = 1'b1;
    end
    check({name, "_accept_seen"}, got, 1'b1);
  endtask

  // Wait for all expectations to be consumed, then idle a few more cycles so
  // any extra request or instruction is flagged by the monitors.
  task automatic wait_drain(input string name);
    for (int i = 0; i < 80 && (exp_addr_q.size() != 0 || exp_slot_q.size() != 0); i++) begin
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check({name, "_addr_left"}, exp_addr_q.size(), 0);
    check({name, "_slot_left"}, exp_slot_q.size(), 0);
    exp_addr_q.delete();
    exp_slot_q.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    rst      = 1'b1;
    Branch   = 1'b0;
    BrPC     = '0;
    id_ready = 1'b1;

    // 1: sequential fetch 0,4,8 with decode always ready.
    mem_extra = 0;
    do_reset();
    expect_fetch(32'h0000_0000, 1'b1);
    expect_fetch(32'h0000_0004, 1'b1);
    expect_fetch(32'h0000_0008, 1'b1);
    set_budget(3);
    wait_drain("t1");
    check("t1_idle_req", imem_req, 1'b1);
    check("t1_idle_addr", imem_addr, 32'h0000_000C);

    // 2: decode stalls, second response parks in the hold buffer.
    do_reset();
    id_ready = 1'b0;
    expect_fetch(32'h0000_0000, 1'b1);
    expect_fetch(32'h0000_0004, 1'b1);
    expect_fetch(32'h0000_0008, 1'b1);
    set_budget(3);
    repeat (10) tick();
    @(negedge clk);
    check("t2_slot_valid", if_valid, 1'b1);
    check("t2_slot_pc", if_pc, 32'h0000_0000);
    check("t2_slot_instr", if_instr, 32'hDEAD_0013);
    check("t2_hold_no_req", imem_req, 1'b0);
    tick();
    id_ready = 1'b1;
    wait_drain("t2");

    // 3: redirect while waiting; the in-flight response is discarded.
    mem_extra = 2;
    do_reset();
    expect_fetch(32'h0000_0000, 1'b0);
    expect_fetch(32'h0000_F100, 1'b1);
    set_budget(2);
    wait_accept("t3");
    tick();
    Branch = 1'b1;
    BrPC   = 32'h0000_F100;
    tick();
    Branch = 1'b0;
    @(negedge clk);
    check("t3_drain_no_req", imem_req, 1'b0);
    check("t3_drain_slot", if_valid, 1'b0);
    wait_drain("t3");

    // 4: redirect in the same cycle as the response strobe.
    mem_extra = 0;
    do_reset();
    expect_fetch(32'h0000_0000, 1'b0);
    expect_fetch(32'h0000_0200, 1'b1);
    set_budget(2);
    wait_accept("t4");
    tick();
    Branch = 1'b1;
    BrPC   = 32'h0000_0200;
    tick();
    Branch = 1'b0;
    @(negedge clk);
    check("t4_slot_dropped", if_valid, 1'b0);
    check("t4_req", imem_req, 1'b1);
    check("t4_addr", imem_addr, 32'h0000_0200);
    wait_drain("t4");

    // 5: wrap-around after the top word, then a misaligned target.
    do_reset();
    tick();
    Branch = 1'b1;
    BrPC   = 32'hFFFF_FFFC;
    tick();
    Branch = 1'b0;
    @(negedge clk);
    check("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
    check("t5_aligned_mis", fetch_misalign, 1'b0);
    tick();
    expect_fetch(32'hFFFF_FFFC, 1'b1);
    expect_fetch(32'h0000_0000, 1'b1);
    set_budget(2);
    wait_drain("t5a");
    tick();
    Branch = 1'b1;
    BrPC   = 32'h0000_00F2;
    tick();
    Branch = 1'b0;
    @(negedge clk);
    check("t5_mis_addr", imem_addr, 32'h0000_00F0);
    check("t5_mis_pulse", fetch_misalign, EXP_MIS);
    @(negedge clk);
    check("t5_mis_clear", fetch_misalign, 1'b0);
    tick();
    expect_fetch(32'h0000_00F0, 1'b1);
    set_budget(1);
    wait_drain("t5b");

    // 6: asynchronous reset while a request is outstanding.
    mem_extra = 2;
    do_reset();
    id_ready = 1'b0;
    expect_fetch(32'h0000_0000, 1'b0);
    expect_fetch(32'h0000_0004, 1'b0);
    set_budget(2);
    wait_accept("t6a");
    wait_accept("t6b");
    tick();
    check("t6_pre_valid", if_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    tick();
    tick();
    mem_extra = 0;
    id_ready  = 1'b1;
    expect_fetch(32'h0000_0000, 1'b1);
    set_budget(1);
    rst = 1'b0;
    wait_drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
